// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose: sits between the execute stage and the data memory. It takes one
// load or store request at a time, drives a single data-memory access, waits
// for the memory to acknowledge it, and for loads hands the returned data to
// the register file for one cycle. An access that never completes is
// abandoned after TIMEOUT cycles and leaves a sticky fault flag behind.
//
// Parameters:
//   DATA_WIDTH  data bus and register value width
//   ADDR_WIDTH  data-memory address width
//   TIMEOUT     ACCESS cycles to wait for dmem_ack before giving up (1..255)
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   req_valid / req_ready   request handshake from the execute stage
//   req_write               1 = store, 0 = load
//   req_addr, req_wdata     access address and store data
//   req_rd                  load destination register
//   dmem_req, dmem_we       data-memory request strobe and write enable
//   dmem_addr, dmem_wdata   data-memory address and write data
//   dmem_ack, dmem_rdata    access complete and load data (valid with ack)
//   reg_d_enable, reg_d,    register-file write port
//   reg_d_value
//   busy                    an access is in flight
//   fault, fault_clear      sticky timeout flag and its clear
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [3:0]            req_rd,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic                  dmem_ack,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  reg_d_enable,
   output logic [3:0]            reg_d,
   output logic [DATA_WIDTH-1:0] reg_d_value,
   output logic                  busy,
   output logic                  fault,
   input  logic                  fault_clear
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ACCESS    = 2'd1;
   localparam logic [1:0] WRITEBACK = 2'd2;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);

   logic [1:0] state;
   logic [7:0] waitCount;
   logic [7:0] waitNext;
   logic [3:0] latchedRd;
   logic       accept;
   logic       timeoutHit;

   // Ready is gated by reset so the execute stage never sees a handshake
   // while the unit is being held in reset.
   assign req_ready  = (state == IDLE) && !reset;
   assign busy       = (state != IDLE);
   assign accept     = req_valid && req_ready;
   assign waitNext   = waitCount + 8'd1;
   assign timeoutHit = (state == ACCESS) && !dmem_ack && (waitNext == TIMEOUT_LIMIT);

   // Main sequencer. The dmem_* outputs double as the latched request, so
   // they are only reloaded on accept and stay stable for the whole access.
   // An ack arriving in the last allowed cycle still completes the access.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         waitCount    <= 8'd0;
         latchedRd    <= 4'd0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         reg_d_enable <= 1'b0;
         reg_d        <= 4'd0;
         reg_d_value  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= ACCESS;
                  waitCount  <= 8'd0;
                  latchedRd  <= req_rd;
                  dmem_req   <= 1'b1;
                  dmem_we    <= req_write;
                  dmem_addr  <= req_addr;
                  dmem_wdata <= req_wdata;
               end
            end
            ACCESS: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (dmem_we) begin
                     state <= IDLE;
                  end else begin
                     state        <= WRITEBACK;
                     reg_d_value  <= dmem_rdata;
                     reg_d        <= latchedRd;
                     reg_d_enable <= (latchedRd != 4'd0);
                  end
               end else if (waitNext == TIMEOUT_LIMIT) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
               end else begin
                  waitCount <= waitNext;
               end
            end
            WRITEBACK: begin
               state        <= IDLE;
               reg_d_enable <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               dmem_req     <= 1'b0;
               reg_d_enable <= 1'b0;
            end
         endcase
      end
   end

   // Sticky timeout flag; a timeout in the same cycle as a clear wins so a
   // fresh fault is never lost.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fault <= 1'b0;
      end else if (timeoutHit) begin
         fault <= 1'b1;
      end else if (fault_clear) begin
         fault <= 1'b0;
      end
   end

endmodule
